cla_multiword_sequencer: RTL and testbench
==========================================

Name: cla_multiword_sequencer

Overview:
- Multi-cycle sequencer performing wide add/subtract (64*WORDS bits) through a single shared CLA_64bit instance, one 64-bit slice per cycle, least-significant slice first.
- Inter-slice carry is held in a register.
- Operands enter on a valid/ready handshake; the result is held on a valid/ready handshake.
- Sits between the register-file/ALU front end and the 64-bit CLA datapath, so wide arithmetic reuses one adder instead of instantiating WORDS adders.

Parameters:
WORDS, 4, number of 64-bit slices per operation; legal range 1..16; operand width W = 64*WORDS.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  sequencer can accept operands (high only in IDLE)
sub  input  1  0 = a+b, 1 = a-b; sampled with operands
a  input  W  operand A, unsigned/two's complement
b  input  W  operand B
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
s  output  W  sum/difference
cout  output  1  final carry-out of top slice (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- States: IDLE, RUN, DONE. Index register idx, width max(1,clog2(WORDS)).
- Reset (async, any state, including mid-RUN): state=IDLE, idx=0, carry=0, s=0, cout=0, ovf=0, out_valid=0, in_ready=1. Partial results are discarded.
- IDLE: in_ready=1.
  - On in_valid: latch a, b, sub into a_r, b_r, sub_r; carry<=sub; idx<=0; s<=0; go RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle, the shared CLA_64bit receives a_r[idx], b_r[idx]^{64{sub_r}} and cin=carry.
  - Register: s[idx] <= slice sum; carry <= slice cout; idx <= idx+1.
  - When idx==WORDS-1:
    - cout <= slice cout.
    - ovf <= (a_top[63] == beff_top[63]) && (sum_top[63] != a_top[63]), where a_top is a_r's top slice, beff_top is the inverted-if-sub top slice of b_r, and sum_top is the top slice sum.
    - Go DONE.
  - The adder's GP/GG outputs are unused.
- DONE: out_valid=1; s, cout and ovf are stable.
  - On out_ready: go IDLE next edge; out_valid drops.
  - in_valid is ignored in DONE. There is no same-cycle accept of new operands.
- Latency: operands accepted at edge T0 → out_valid high after edge T0+WORDS. Throughput is one operation per WORDS+2 cycles with out_ready tied high.
- WORDS=1: a single RUN cycle; idx is a constant 0.
- Outputs s/cout/ovf keep their previous result values through IDLE. They are overwritten only as slices complete, except that s is cleared on accept.
- Arithmetic is modulo 2^W.
- Subtraction is A + ~B + 1, with the +1 injected as the initial carry.
- All outputs are registered. No combinational path exists from in_valid/out_ready to any output.

Test Plan:
- Reset: assert rst mid-idle, then deassert → in_ready=1, out_valid=0, s=0, cout=0, ovf=0. WORDS=4 for all scenarios below.
- Slice carry: a=0x0…0_FFFFFFFFFFFFFFFF, b=1, sub=0, accept at T0 → out_valid at T0+4 exactly; s=0x0…1_0000000000000000, cout=0, ovf=0.
- Full ripple and signed overflow:
  - a=2^256-1, b=1 → s=0, cout=1, ovf=0.
  - a=2^255-1, b=1 → s=2^255, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1 → s=2^256-2, cout=0, ovf=0. Then a=7, b=5, sub=1 → s=2, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → s/cout/ovf stable and in_ready=0. A pulse of in_valid with new operands is ignored. Raise out_ready → out_valid=0 and in_ready=1 on the next edge.
- Reset mid-RUN: accept a=2^256-1, b=1; assert rst at the cycle with idx=2 → all outputs 0 and state IDLE immediately. A following a=3, b=4 gives s=7 after 4 cycles.

Source files
------------

// File: rtl/cla_multiword_sequencer.sv
// Wide (64*WORDS-bit) add/subtract sequenced through one shared 64-bit CLA,
// one slice per cycle, least-significant slice first, with a registered inter-slice carry.

module CLA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        gp,
  output logic        gg
);
  logic [63:0] g;
  logic [63:0] p;
  logic [63:0] c_bit;
  logic [16:0] c_grp;
  logic [16:0] gg_chain;
  logic [15:0] grp_g;
  logic [15:0] grp_p;

  assign g           = a & b;
  assign p           = a ^ b;
  assign c_grp[0]    = cin;
  assign gg_chain[0] = 1'b0;

  // 4-bit lookahead groups; group carries then chain across the 16 groups
  for (genvar gi = 0; gi < 16; gi++) begin : g_grp
    logic [3:0] gl;
    logic [3:0] pl;
    logic       ci;
    assign gl = g[4*gi +: 4];
    assign pl = p[4*gi +: 4];
    assign ci = c_grp[gi];
    assign c_bit[4*gi]   = ci;
    assign c_bit[4*gi+1] = gl[0] | (pl[0] & ci);
    assign c_bit[4*gi+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
    assign c_bit[4*gi+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                         | (pl[2] & pl[1] & pl[0] & ci);
    assign grp_g[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                     | (pl[3] & pl[2] & pl[1] & gl[0]);
    assign grp_p[gi] = &pl;
    assign c_grp[gi+1]    = grp_g[gi] | (grp_p[gi] & ci);
    assign gg_chain[gi+1] = grp_g[gi] | (grp_p[gi] & gg_chain[gi]);
  end

  assign sum  = p ^ c_bit;
  assign cout = c_grp[16];
  assign gp   = &grp_p;
  assign gg   = gg_chain[16];
endmodule

module cla_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sub,
  input  logic [64*WORDS-1:0] a,
  input  logic [64*WORDS-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [64*WORDS-1:0] s,
  output logic              cout,
  output logic              ovf
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [IDXW-1:0]        idx_reg;
  logic                   carry_reg;
  logic                   sub_reg;
  logic [WORDS-1:0][63:0] a_reg;
  logic [WORDS-1:0][63:0] b_reg;
  logic [WORDS-1:0][63:0] s_reg;
  logic                   cout_reg;
  logic                   ovf_reg;
  logic                   out_valid_reg;
  logic                   in_ready_reg;

  logic [63:0] slice_a;
  logic [63:0] slice_b;
  logic [63:0] slice_sum;
  logic        slice_cout;
  logic        cla_gp_unused;
  logic        cla_gg_unused;

  assign slice_a = a_reg[idx_reg];
  assign slice_b = b_reg[idx_reg] ^ {64{sub_reg}};

  CLA_64bit u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout),
    .gp   (cla_gp_unused),
    .gg   (cla_gg_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      sub_reg       <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            sub_reg      <= sub;
            carry_reg    <= sub;  // the +1 of A + ~B + 1
            idx_reg      <= '0;
            s_reg        <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          s_reg[idx_reg] <= slice_sum;
          carry_reg      <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg      <= slice_cout;
            ovf_reg       <= (slice_a[63] == slice_b[63]) && (slice_sum[63] != slice_a[63]);
            out_valid_reg <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s         = s_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed bench for cla_multiword_sequencer (WORDS=4): hand-computed sums,
// latency, backpressure hold and asynchronous reset during a run.

module tb_cla_multiword_sequencer;
  localparam int WORDS = 4;
  localparam int W     = 64 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_multiword_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then count edges until out_valid (bounded).
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          output int lat);
    check("in_ready_before_accept", W'(in_ready), W'(1));
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_out_valid", W'(out_valid), W'(0));
    check("retire_in_ready", W'(in_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    start_op(av, bv, sv, lat);
    $display("op %s: sub=%0d lat=%0d s=%h cout=%0d ovf=%0d", tag, sv, lat, s, cout, ovf);
    check({tag, "_latency"}, W'(lat), W'(WORDS));
    check({tag, "_s"}, s, es);
    check({tag, "_cout"}, W'(cout), W'(ec));
    check({tag, "_ovf"}, W'(ovf), W'(eo));
    retire();
  endtask

  logic [W-1:0] all_ones;
  logic [W-1:0] max_pos;
  logic [W-1:0] min_neg;

  initial begin
    int lat;
    all_ones  = '1;
    max_pos   = {1'b0, {(W-1){1'b1}}};
    min_neg   = {1'b1, {(W-1){1'b0}}};
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    $display("op reset: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_s", s, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(ovf), W'(0));

    run_op("slice_carry", W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, {W'(1)} << 64, 1'b0, 1'b0);
    run_op("full_ripple", all_ones, W'(1), 1'b0, '0, 1'b1, 1'b0);
    run_op("signed_ovf", max_pos, W'(1), 1'b0, min_neg, 1'b0, 1'b1);
    run_op("sub_5_7", W'(5), W'(7), 1'b1, all_ones - W'(1), 1'b0, 1'b0);

    // Backpressure: 7-5 held for 10 cycles with a stray in_valid pulse in between
    start_op(W'(7), W'(5), 1'b1, lat);
    $display("op sub_7_5: lat=%0d s=%h cout=%0d ovf=%0d", lat, s, cout, ovf);
    check("sub_7_5_latency", W'(lat), W'(WORDS));
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = W'(100); b = W'(200); sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_s", s, W'(2));
    check("bp_cout", W'(cout), W'(1));
    check("bp_ovf", W'(ovf), W'(0));
    check("bp_out_valid", W'(out_valid), W'(1));
    check("bp_in_ready", W'(in_ready), W'(0));
    retire();

    // Asynchronous reset while idx==2 of a run
    a = all_ones; b = W'(1); sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("op mid_run_reset: in_ready=%0d out_valid=%0d cout=%0d", in_ready, out_valid, cout);
    check("mrst_in_ready", W'(in_ready), W'(1));
    check("mrst_out_valid", W'(out_valid), W'(0));
    check("mrst_s", s, '0);
    check("mrst_cout", W'(cout), W'(0));
    check("mrst_ovf", W'(ovf), W'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset_3_4", W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
